alu_md_seq: RTL and testbench

Parametrised successor to the integer ALU: a WIDTH-bit execute unit with single-cycle logic/arithmetic/shift ops and an iterative multiply/divide engine writing HI/LO. It replaces the fixed-wait multiply with a ready/valid-style handshake and adds divide, extra shifts and compares. It sits in the EX stage, fed by the decoder's 6-bit funct code.

---
 rtl/alu_md_pkg.sv | 48 ++++
 rtl/alu_md_if.sv | 26 ++
 rtl/alu_md_engine.sv | 188 ++++++++++++++++++
 rtl/alu_md_seq.sv | 128 ++++++++++++
 tb/tb_alu_md_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_md_pkg.sv
// alu_md_seq shared definitions: funct codes, engine states, result select.
// Signed MULT/DIV support is compiled in with ALU_SIGNED_MD_EN.
package alu_md_pkg;

  localparam int FW = 6;

  localparam logic [FW-1:0] F_SLL   = 6'd0;
  localparam logic [FW-1:0] F_SRL   = 6'd2;
  localparam logic [FW-1:0] F_SRA   = 6'd3;
  localparam logic [FW-1:0] F_MFHI  = 6'd16;
  localparam logic [FW-1:0] F_MFLO  = 6'd18;
  localparam logic [FW-1:0] F_MULT  = 6'd24;
  localparam logic [FW-1:0] F_MULTU = 6'd25;
  localparam logic [FW-1:0] F_DIV   = 6'd26;
  localparam logic [FW-1:0] F_DIVU  = 6'd27;
  localparam logic [FW-1:0] F_ADD   = 6'd32;
  localparam logic [FW-1:0] F_SUB   = 6'd34;
  localparam logic [FW-1:0] F_AND   = 6'd36;
  localparam logic [FW-1:0] F_OR    = 6'd37;
  localparam logic [FW-1:0] F_XOR   = 6'd38;
  localparam logic [FW-1:0] F_NOR   = 6'd39;
  localparam logic [FW-1:0] F_SLT   = 6'd42;
  localparam logic [FW-1:0] F_SLTU  = 6'd43;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } md_state_e;

  typedef enum logic [3:0] {
    SEL_ZERO,
    SEL_ADD,
    SEL_SUB,
    SEL_AND,
    SEL_OR,
    SEL_XOR,
    SEL_NOR,
    SEL_SLT,
    SEL_SLTU,
    SEL_SLL,
    SEL_SRL,
    SEL_SRA,
    SEL_HI,
    SEL_LO
  } sel_e;

endpackage

// File: rtl/alu_md_if.sv
// alu_md_seq request/result bundle.
// Master drives the request; slave is the execute unit.
interface alu_md_if
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [FW-1:0]    Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             out_valid;
  logic             done;
  logic [WIDTH-1:0] Output;

  modport master (
    output in_valid, Signal, dataA, dataB,
    input  busy, out_valid, done, Output
  );

  modport slave (
    input  in_valid, Signal, dataA, dataB,
    output busy, out_valid, done, Output
  );
endinterface

// File: rtl/alu_md_engine.sv
// Iterative mul/div engine: shift-add multiply, restoring divide, HI/LO.
// ALU_SIGNED_MD_EN adds magnitude conversion and the FIX negation step.
module alu_md_engine
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);

  md_state_e        st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] wb_q, wb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   msum, shd;
  logic [WIDTH-1:0] dif;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             run_sgn;

  // wh/wl hold {acc,multiplier} for mul and {rem,quotient} for div
  always_comb begin
    msum = wl_q[0] ? ({1'b0, wh_q} + {1'b0, wb_q})
                   : {1'b0, wh_q};
    shd  = {wh_q, wl_q[WIDTH-1]};
    ge   = shd >= {1'b0, wb_q};
    dif  = shd[WIDTH-1:0] - wb_q;
    if (div_q) begin
      step_hi = ge ? dif : shd[WIDTH-1:0];
      step_lo = {wl_q[WIDTH-2:0], ge};
    end else begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], wl_q[WIDTH-1:1]};
    end
  end

`ifdef ALU_SIGNED_MD_EN
  logic             sgn_q, nlo_q, nhi_q;
  logic [2*WIDTH-1:0] prod_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
      nlo_q <= 1'b0;
      nhi_q <= 1'b0;
    end else if (st_q == S_IDLE && start_i) begin
      sgn_q <= sgn_i;
      nhi_q <= sgn_i & a_i[WIDTH-1];
      nlo_q <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end
  end

  assign a_mag  = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag  = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign prod_n = -{wh_q, wl_q};
  assign run_sgn = sgn_q;

  always_comb begin
    fix_hi = wh_q;
    fix_lo = wl_q;
    if (div_q) begin
      if (nlo_q) fix_lo = -wl_q;
      if (nhi_q) fix_hi = -wh_q;
    end else if (nlo_q) begin
      {fix_hi, fix_lo} = prod_n;
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn_i;
  assign a_mag   = a_i;
  assign b_mag   = b_i;
  assign fix_hi  = wh_q;
  assign fix_lo  = wl_q;
  assign run_sgn = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    wh_d   = wh_q;
    wl_d   = wl_q;
    wb_d   = wb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div_d  = div_q;
    zero_d = zero_q;
    done_d = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start_i) begin
          div_d = div_i;
          cnt_d = CW'(WIDTH - 1);
          if (div_i && b_i == '0) begin
            zero_d = 1'b1;
            wh_d   = a_i;
            st_d   = S_FIX;
          end else begin
            zero_d = 1'b0;
            wh_d   = '0;
            wl_d   = a_mag;
            wb_d   = b_mag;
            st_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        wh_d  = step_hi;
        wl_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (run_sgn) begin
            st_d = S_FIX;
          end else begin
            hi_d   = step_hi;
            lo_d   = step_lo;
            done_d = 1'b1;
            st_d   = S_IDLE;
          end
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        st_d   = S_IDLE;
        if (zero_q) begin
          hi_d = wh_q;
          lo_d = '1;
        end else begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      wh_q   <= '0;
      wl_q   <= '0;
      wb_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      div_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      wh_q   <= wh_d;
      wl_q   <= wl_d;
      wb_q   <= wb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      div_q  <= div_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  assign busy_o = (st_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md_seq.sv
// EX-stage ALU: single-cycle ops, registered Output, mul/div handshake.
// Define ALU_SIGNED_MD_EN to enable signed MULT/DIV.
module alu_md_seq
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_md_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH-1:0] hi, lo;
  logic [SW-1:0]    sh;
  sel_e             sel;
  logic             md_go, md_div, md_sgn;
  logic             accept, busy;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ov_q, ov_d;

  assign a      = bus.dataA;
  assign b      = bus.dataB;
  assign sh     = b[SW-1:0];
  assign accept = bus.in_valid && !busy;

  always_comb begin
    sel    = SEL_ZERO;
    md_go  = 1'b0;
    md_div = 1'b0;
    md_sgn = 1'b0;
    unique case (bus.Signal)
      F_SLL:   sel = SEL_SLL;
      F_SRL:   sel = SEL_SRL;
      F_SRA:   sel = SEL_SRA;
      F_MFHI:  sel = SEL_HI;
      F_MFLO:  sel = SEL_LO;
      F_ADD:   sel = SEL_ADD;
      F_SUB:   sel = SEL_SUB;
      F_AND:   sel = SEL_AND;
      F_OR:    sel = SEL_OR;
      F_XOR:   sel = SEL_XOR;
      F_NOR:   sel = SEL_NOR;
      F_SLT:   sel = SEL_SLT;
      F_SLTU:  sel = SEL_SLTU;
      F_MULTU: md_go = 1'b1;
      F_DIVU: begin
        md_go  = 1'b1;
        md_div = 1'b1;
      end
`ifdef ALU_SIGNED_MD_EN
      F_MULT: begin
        md_go  = 1'b1;
        md_sgn = 1'b1;
      end
      F_DIV: begin
        md_go  = 1'b1;
        md_div = 1'b1;
        md_sgn = 1'b1;
      end
`endif
      default: sel = SEL_ZERO;
    endcase
  end

  always_comb begin
    res = '0;
    unique case (sel)
      SEL_ADD:  res = a + b;
      SEL_SUB:  res = a - b;
      SEL_AND:  res = a & b;
      SEL_OR:   res = a | b;
      SEL_XOR:  res = a ^ b;
      SEL_NOR:  res = ~(a | b);
      SEL_SLT:  res = {{(WIDTH-1){1'b0}},
                       $signed(a) < $signed(b)};
      SEL_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
      SEL_SLL:  res = a << sh;
      SEL_SRL:  res = a >> sh;
      SEL_SRA:  res = $signed(a) >>> sh;
      SEL_HI:   res = hi;
      SEL_LO:   res = lo;
      default:  res = '0;
    endcase
  end

  alu_md_engine #(
    .WIDTH (WIDTH)
  ) u_eng (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (accept && md_go),
    .div_i   (md_div),
    .sgn_i   (md_sgn),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (bus.done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // mul/div acceptance leaves the last single-cycle result in place
  always_comb begin
    out_d = out_q;
    ov_d  = 1'b0;
    if (accept && !md_go) begin
      out_d = res;
      ov_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.out_valid = ov_q;
  assign bus.Output    = out_q;

endmodule

// File: tb/tb_alu_md_seq.sv
// Scoreboard bench for alu_md_seq (WIDTH 32).
// Signed cases are exercised when ALU_SIGNED_MD_EN is defined.
module tb_alu_md_seq;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  alu_md_if #(.WIDTH(32)) bus ();

  alu_md_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ov", bus.Output, 32'hDEAD_BEEF);
      end else begin
        chk(tag_q.pop_front(), bus.Output, exp_q.pop_front());
      end
    end
  end

  function automatic bit is_md(input logic [5:0] f);
`ifdef ALU_SIGNED_MD_EN
    return f == 25 || f == 27 || f == 24 || f == 26;
`else
    return f == 25 || f == 27;
`endif
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] f,
                                          input logic [31:0] a, b);
    logic [4:0] s;
    s = b[4:0];
    case (f)
      6'd0:  return a << s;
      6'd2:  return a >> s;
      6'd3:  return 32'($signed(a) >>> s);
      6'd16: return m_hi;
      6'd18: return m_lo;
      6'd32: return a + b;
      6'd34: return a - b;
      6'd36: return a & b;
      6'd37: return a | b;
      6'd38: return a ^ b;
      6'd39: return ~(a | b);
      6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd43: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_md(input logic [5:0] f, input logic [31:0] a, b);
    logic [63:0] p;
    case (f)
      6'd25: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      6'd27: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
`ifdef ALU_SIGNED_MD_EN
      6'd24: begin
        p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      6'd26: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a; m_hi = 0;
        end else begin
          m_lo = 32'($signed(a) / $signed(b));
          m_hi = 32'($signed(a) % $signed(b));
        end
      end
`endif
      default: ;
    endcase
  endtask

  // call only in the post-edge phase; returns just after the accepting edge
  task automatic issue(input logic [5:0] f, input logic [31:0] a, b,
                       input string tag);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.Signal   = f;
    bus.dataA    = a;
    bus.dataB    = b;
    while (bus.busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk({tag, "_acc_timeout"}, 32'(n), 32'd0);
    if (is_md(f)) model_md(f, a, b);
    else begin
      exp_q.push_back(ref_alu(f, a, b));
      tag_q.push_back(tag);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    chk({tag, "_ov"}, 32'(bus.out_valid), is_md(f) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.done !== 1'b1 && n < 200);
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  // md op with MFLO held during busy so it lands in the done cycle
  task automatic md_read(input logic [5:0] f, input logic [31:0] a, b,
                         input int lat, input string tag);
    int k;
    issue(f, a, b, tag);
    k = acc_cyc;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    issue(6'd18, 0, 0, {tag, "_lo"});
    chk({tag, "_done_lat"}, 32'(done_cyc - k), 32'(lat));
    chk({tag, "_acc_lat"}, 32'(acc_cyc - k), 32'(lat + 1));
    issue(6'd16, 0, 0, {tag, "_hi"});
  endtask

  logic [5:0] ops [11] = '{0, 2, 3, 32, 34, 36, 37, 38, 39, 42, 43};

  initial begin
    int k;
    int dc;
    logic [31:0] ra, rb;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.Signal = '0;
    bus.dataA = '0;
    bus.dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", bus.Output, 0);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(6'd16, 0, 0, "rst_hi");
    issue(6'd18, 0, 0, "rst_lo");
    issue(6'd32, 7, 32'hFFFF_FFFF, "add_wrap");
    issue(6'd34, 3, 5, "sub_neg");
    issue(6'd42, 32'hFFFF_FFFF, 1, "slt");
    issue(6'd43, 32'hFFFF_FFFF, 1, "sltu");
    issue(6'd3, 32'h8000_0000, 4, "sra");
    issue(6'd2, 32'h8000_0000, 4, "srl");
    issue(6'd0, 32'h0000_0001, 32'h24, "sll_mask");
    issue(6'd36, 32'hF0F0_1234, 32'hFF00_FF00, "and");
    issue(6'd37, 32'hF0F0_1234, 32'h0F00_0001, "or");
    issue(6'd38, 32'hAAAA_5555, 32'hFFFF_0000, "xor");
    issue(6'd39, 32'h1234_0000, 32'h0000_5678, "nor");
    issue(6'd63, 32'h1234, 32'h5678, "illegal63");
    issue(6'd32, 7, 32'hFFFF_FFFF, "add_pre_mul");

    issue(6'd25, 32'hFFFF_FFFF, 2, "multu");
    k = acc_cyc;
    chk("multu_busy", 32'(bus.busy), 1);
    chk("multu_out_hold", bus.Output, 32'd6);
    issue(6'd32, 32'h10, 32'h20, "add_held");
    chk("multu_done_lat", 32'(done_cyc - k), 32);
    chk("add_held_acc", 32'(acc_cyc - k), 33);
    issue(6'd16, 0, 0, "multu_hi");
    issue(6'd18, 0, 0, "multu_lo");

    md_read(6'd27, 100, 7, 32, "divu");
    issue(6'd27, 5, 0, "divu0");
    chk("divu0_busy", 32'(bus.busy), 1);
    wait_done("divu0", 1);
    issue(6'd18, 0, 0, "divu0_lo");
    issue(6'd16, 0, 0, "divu0_hi");

`ifdef ALU_SIGNED_MD_EN
    md_read(6'd26, 32'hFFFF_FFF9, 2, 33, "div_s");
    md_read(6'd24, 32'hFFFF_FFFD, 4, 33, "mult_s");
    md_read(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_min");
    md_read(6'd26, 32'hFFFF_FFF9, 0, 1, "div_s0");
`else
    issue(6'd26, 32'hFFFF_FFF9, 2, "div_illegal");
    issue(6'd24, 32'hFFFF_FFFD, 4, "mult_illegal");
`endif

    for (int i = 0; i < 30; i++) begin
      issue(ops[$urandom_range(0, 10)], $urandom, $urandom, "rnd_op");
    end
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom | 32'h1;
      md_read((i % 2 == 0) ? 6'd25 : 6'd27, ra, rb, 32, "rnd_md");
    end

    issue(6'd32, 9, 1, "add_pre_rst");
    issue(6'd25, 32'h1234_5678, 32'h9ABC_DEF0, "multu_abort");
    repeat (9) begin @(posedge clk); #1; end
    dc = done_cnt;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_out", bus.Output, 0);
    chk("abort_ov", 32'(bus.out_valid), 0);
    chk("abort_done", 32'(bus.done), 0);
    issue(6'd32, 1, 2, "add_post_rst");
    issue(6'd16, 0, 0, "abort_hi");
    issue(6'd18, 0, 0, "abort_lo");
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done_cnt - dc), 0);
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
